// File: rtl/alu_defs.sv
// Shared definitions for the sequential add/subtract unit: FSM states,
// flag register layout and saturation constants.
package alu_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flag register layout, MSB first.
    typedef struct packed {
        logic neg;
        logic zero;
        logic carry;
        logic ovfl;
    } flags_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder slice; also exposes the carry into its top bit so the
// caller can derive signed overflow on the most significant slice.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_top
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_top = c[CHUNK-1];

endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sat_addsub_seq.sv
// Multi-cycle signed add/subtract: one CHUNK-bit slice per cycle through a
// single reused adder slice, with optional saturation and a registered flag set.
module sat_addsub_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             carry,
    output logic             zero,
    output logic             neg
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
    localparam logic [MAX_W-1:0] MIN_FULL = sat_min(WIDTH);
    localparam logic [MAX_W-1:0] MAX_FULL = sat_max(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MIN  = MIN_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MAX  = MAX_FULL[WIDTH-1:0];

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || WIDTH > MAX_W) begin : g_bad_params
        $error("sat_addsub_seq: illegal WIDTH/CHUNK combination");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // already inverted for subtraction
    logic [WIDTH-1:0]   acc;      // working sum, filled slice by slice
    logic               cy_q;
    logic               sat_q;
    logic [WIDTH-1:0]   sum_q;
    flags_t             flags_q;

    logic [CHUNK-1:0]   slice_s;
    logic               slice_co;
    logic               slice_ctop;
    logic [WIDTH-1:0]   raw;
    logic [WIDTH-1:0]   result;
    logic               ovfl_raw;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK*int'(cnt) +: CHUNK]),
        .b     (b_q[CHUNK*int'(cnt) +: CHUNK]),
        .cin   (cy_q),
        .s     (slice_s),
        .cout  (slice_co),
        .c_top (slice_ctop)
    );

    // Full raw sum and clamp are only meaningful on the last slice, where the
    // top slice comes straight from the adder rather than from acc.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        raw = acc;
        raw[WIDTH-CHUNK +: CHUNK] = slice_s;
        ovfl_raw = slice_ctop ^ slice_co;
        result = raw;
        if (ovfl_raw && sat_q) begin
            result = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            cy_q    <= 1'b0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{sub}};
                        cy_q  <= sub;
                        sat_q <= sat_en;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc[CHUNK*int'(cnt) +: CHUNK] <= slice_s;
                    cy_q <= slice_co;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q         <= result;
                        flags_q.ovfl  <= ovfl_raw;
                        flags_q.carry <= slice_co;
                        flags_q.zero  <= (result == '0);
                        flags_q.neg   <= result[WIDTH-1];
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (state == ST_IDLE);
    assign res_valid   = (state == ST_DONE);
    assign sum         = sum_q;
    assign ovfl        = flags_q.ovfl;
    assign carry       = flags_q.carry;
    assign zero        = flags_q.zero;
    assign neg         = flags_q.neg;

endmodule

// File: tb/tb_sat_addsub_seq.sv
// Self-checking bench for sat_addsub_seq: directed corner cases, backpressure,
// mid-operation reset and a randomized back-to-back sweep against a reference model.
module tb_sat_addsub_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovfl;
        logic        carry;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        op_sub = 1'b0;
    logic        op_sat = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] sum;
    logic        ovfl, carry, zero, neg;
    res_t        obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {sum, ovfl, carry, zero, neg};

    sat_addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (op_a),
        .b           (op_b),
        .sub         (op_sub),
        .sat_en      (op_sat),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .ovfl        (ovfl),
        .carry       (carry),
        .zero        (zero),
        .neg         (neg)
    );

    // Reference: exact integer arithmetic, then range check and clamp.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic sat);
        res_t r;
        int   sa, sb, exact;
        logic [31:0] ex_bits;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        exact = sub ? sa - sb : sa + sb;
        ex_bits = exact;
        r.ovfl  = (exact > 32767) || (exact < -32768);
        r.carry = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        if (r.ovfl && sat) r.sum = (exact > 0) ? 16'h7FFF : 16'h8000;
        else               r.sum = ex_bits[15:0];
        r.zero = (r.sum == 16'h0000);
        r.neg  = r.sum[15];
        return r;
    endfunction

    // Presents one op, scrambles the inputs after acceptance, and waits for the
    // result (left pending with res_ready low). lat counts cycles after accept.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sat, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!start_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        op_a = a; op_b = b; op_sub = sub; op_sat = sat;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        op_sub = 1'($urandom); op_sat = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h res_valid=%b, want res=0 res_valid=0", obs, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got start_ready=%b res_valid=%b, want 1/0", start_ready, res_valid);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[7];
        int   lat;
        vecs[0] = {16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h2143, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = {16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = {16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = {16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = {16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = {16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, lat);
            checks++;
            if (lat != N) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, N);
            end
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("FAIL directed[%0d] %h%s%h sat=%b: got {sum,ovfl,carry,zero,neg}=%h, want %h",
                         i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, vecs[i].sat, obs, vecs[i].exp);
            end
            take();
            checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_handshake[%0d]: got res_valid=%b start_ready=%b, want 0/1", i, res_valid, start_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t exp;
        int   lat;
        exp = model(16'h4321, 16'h1111, 1'b1, 1'b0);
        issue(16'h4321, 16'h1111, 1'b1, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'b1;
            op_a = 16'h7FFF; op_b = 16'h7FFF; op_sub = 1'b0; op_sat = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== exp || res_valid !== 1'b1 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: got res=%h res_valid=%b start_ready=%b, want res=%h 1/0",
                         i, obs, res_valid, start_ready, exp);
            end
        end
        start_valid = 1'b0;
        take();
        checks++;
        if (obs !== exp || start_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got res=%h start_ready=%b res_valid=%b, want res=%h 1/0",
                     obs, start_ready, res_valid, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        op_a = 16'h7FFF; op_b = 16'h0001; op_sub = 1'b0; op_sat = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || res_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run: got res=%h res_valid=%b start_ready=%b, want 0/0/1",
                     obs, res_valid, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if (lat != N || obs !== {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_op: got res=%h lat=%0d, want res=%h lat=%0d",
                     obs, lat, {16'h0002, 4'b0000}, N);
        end
        take();
    endtask

    task automatic test_back_to_back();
        res_t exp;
        res_t q[$];
        int   n_acc, n_res, last_acc;
        localparam int OPS = 40;
        n_acc = 0; n_res = 0; last_acc = -1;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < OPS * (N + 2) + 50 && n_res < OPS; cyc++) begin
            @(negedge clk);
            if (res_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_result: got res=%h with no op outstanding", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h, want %h", n_res, obs, exp);
                    end
                end
                n_res++;
            end
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: op_a = 16'h7FFF;
                    1: op_a = 16'h8000;
                    2: op_a = 16'hFFFF;
                    default: op_a = 16'h0000;
                endcase
            end else begin
                op_a = 16'($urandom);
            end
            op_b   = 16'($urandom);
            op_sub = 1'($urandom_range(0, 1));
            op_sat = 1'($urandom_range(0, 1));
            start_valid = (n_acc < OPS);
            if (start_valid && start_ready) begin
                q.push_back(model(op_a, op_b, op_sub, op_sat));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != N + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", n_acc, cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
        end
        start_valid = 1'b0;
        res_ready   = 1'b0;
        checks++;
        if (n_res != OPS) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want %0d", n_res, OPS);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
